// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared serial link parameters and helpers
// Purpose: link-wide channel/lane defaults and the flit split helper.
//          The TX framer and the RX deframer both size their packets with
//          flit_splits so the two ends always agree on flits per packet.
// Ports:   none (package)
package serial_link_pkg;

   localparam int NumChannels = 2;
   localparam int NumLanes    = 4;

   // Number of flits needed to carry one wrapped packet (ceiling division).
   function automatic int flit_splits(input int wrap_w, input int flit_w);
      return (wrap_w + flit_w - 1) / flit_w;
   endfunction

endpackage

// File: rtl/serial_link_rx_deframer_if.sv
// rtl/serial_link_rx_deframer_if.sv - handshake/bus bundle of the RX deframer
// Purpose: groups the flit input stream, packet output stream, credit
//          reporting and control signals of serial_link_rx_deframer.
// Ports (slave = deframer side):
//   clear_i               in   synchronous flush
//   flit_i/flit_valid_i   in   incoming flit stream, flit_ready_o out
//   data_o/user_o/valid_o out  packet stream, ready_i in
//   credits_rcvd_o(_valid_o) out  credit field of the last completed packet
//   credits_free_o        out  freed slots not yet returned
//   credits_free_take_i   in   local TX consumed credits_free_o
//   overflow_o            out  sticky peer credit violation
interface serial_link_rx_deframer_if #(
   parameter int unsigned FlitWidth    = 16,
   parameter int unsigned PayloadWidth = 64,
   parameter int unsigned UserWidth    = 8,
   parameter int unsigned CreditWidth  = 4,
   parameter int unsigned FreeWidth    = 4
);

   logic                    clear_i;
   logic [FlitWidth-1:0]    flit_i;
   logic                    flit_valid_i;
   logic                    flit_ready_o;
   logic [PayloadWidth-1:0] data_o;
   logic [UserWidth-1:0]    user_o;
   logic                    valid_o;
   logic                    ready_i;
   logic [CreditWidth-1:0]  credits_rcvd_o;
   logic                    credits_rcvd_valid_o;
   logic [FreeWidth-1:0]    credits_free_o;
   logic                    credits_free_take_i;
   logic                    overflow_o;

   modport slave (
      input  clear_i, flit_i, flit_valid_i, ready_i, credits_free_take_i,
      output flit_ready_o, data_o, user_o, valid_o, credits_rcvd_o,
             credits_rcvd_valid_o, credits_free_o, overflow_o
   );

   modport master (
      output clear_i, flit_i, flit_valid_i, ready_i, credits_free_take_i,
      input  flit_ready_o, data_o, user_o, valid_o, credits_rcvd_o,
             credits_rcvd_valid_o, credits_free_o, overflow_o
   );

endinterface

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - valid/ready packet FIFO without fall-through
// Purpose: Depth-entry FIFO; a push becomes visible at the output the cycle
//          after it is accepted. When full, a same-cycle pop frees the slot
//          for a push, so ready_o includes the pop.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   flush_i             synchronous flush, wins over push/pop
//   data_i/valid_i      push side, ready_o out
//   data_o/valid_o      pop side (head entry), ready_i in
module stream_fifo #(
   parameter int unsigned DataWidth = 8,
   parameter int unsigned Depth     = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic [DataWidth-1:0] data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic [DataWidth-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i
);

   localparam int unsigned AddrWidth  = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CountWidth = $clog2(Depth + 1);

   logic [DataWidth-1:0]  mem [Depth];
   logic [AddrWidth-1:0]  wr_ptr;
   logic [AddrWidth-1:0]  rd_ptr;
   logic [CountWidth-1:0] count;
   logic                  full;
   logic                  push;
   logic                  pop;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [AddrWidth-1:0] ptr_inc(input logic [AddrWidth-1:0] p);
      return (p == AddrWidth'(Depth - 1)) ? '0 : p + AddrWidth'(1);
   endfunction

   assign full    = (count == CountWidth'(Depth));
   assign valid_o = (count != '0);
   assign pop     = valid_o & ready_i;
   assign ready_o = ~full | pop;
   assign push    = valid_i & ready_o;
   assign data_o  = mem[rd_ptr];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(Depth); i++) begin
            mem[i] <= '0;
         end
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= data_i;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + CountWidth'(1);
            2'b01:   count <= count - CountWidth'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/serial_link_rx_deframer.sv
// rtl/serial_link_rx_deframer.sv - serial link RX deframer
// Purpose: assembles PayloadSplits flits into one wrapped packet
//          {data, user, credits, credits_only}, reports the piggy-backed
//          credit field, buffers data packets in a NumCredits-deep FIFO and
//          counts freed slots for credit return.
// Ports:
//   clk_i  in  clock
//   rst_i  in  asynchronous active-high reset
//   bus    slave modport of serial_link_rx_deframer_if (flit input stream,
//          packet output stream, credit reporting, clear, overflow)
module serial_link_rx_deframer #(
   parameter int unsigned PayloadWidth = 64,
   parameter int unsigned UserWidth    = 8,
   parameter int unsigned CreditWidth  = 4,
   parameter int unsigned NumChannels  = serial_link_pkg::NumChannels,
   parameter int unsigned NumLanes     = serial_link_pkg::NumLanes,
   parameter int unsigned NumCredits   = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   serial_link_rx_deframer_if.slave bus
);

   localparam int unsigned FlitWidth     = NumChannels * NumLanes * 2;
   localparam int unsigned WrapWidth     = PayloadWidth + UserWidth + CreditWidth + 1;
   localparam int unsigned PayloadSplits = serial_link_pkg::flit_splits(WrapWidth, FlitWidth);
   localparam int unsigned FreeWidth     = $clog2(NumCredits + 1);
   localparam int unsigned IdxWidth      = (PayloadSplits > 1) ? $clog2(PayloadSplits) : 1;
   localparam int unsigned PacketWidth   = PayloadWidth + UserWidth;

   logic [IdxWidth-1:0]    idx;
   logic                   last;
   logic                   stall;
   logic                   accept;
   logic [WrapWidth-1:0]   wrap;
   logic                   flag;
   logic [CreditWidth-1:0] credits;
   logic [PacketWidth-1:0] push_data;
   logic                   push_valid;
   logic                   push_ready;
   logic [PacketWidth-1:0] pop_data;
   logic                   pop_valid;
   logic                   handshake;
   logic [FreeWidth-1:0]   free_cnt;
   logic [CreditWidth-1:0] credits_rcvd;
   logic                   credits_rcvd_valid;
   logic                   overflow;

   // ---------------------------------------------------------------------
   // Flit assembly: earlier flits are held in slots, the last flit is used
   // straight from the input so the packet completes on its acceptance.
   // ---------------------------------------------------------------------
   if (PayloadSplits > 1) begin : gen_multi
      localparam int unsigned NumSlots = PayloadSplits - 1;

      logic [NumSlots-1:0][FlitWidth-1:0]  slots;
      logic [PayloadSplits*FlitWidth-1:0]  wrap_full;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            slots <= '0;
         end else if (accept && !last) begin
            for (int s = 0; s < int'(NumSlots); s++) begin
               if (idx == IdxWidth'(s)) begin
                  slots[s] <= bus.flit_i;
               end
            end
         end
      end

      assign wrap_full = {bus.flit_i, slots};
      assign wrap      = wrap_full[WrapWidth-1:0];

      // Padding bits of the last flit carry nothing.
      if (PayloadSplits * FlitWidth > WrapWidth) begin : gen_pad
         logic unused_pad;
         assign unused_pad = ^wrap_full[PayloadSplits*FlitWidth-1:WrapWidth];
      end
   end else begin : gen_single
      assign wrap = bus.flit_i[WrapWidth-1:0];

      if (FlitWidth > WrapWidth) begin : gen_pad
         logic unused_pad;
         assign unused_pad = ^bus.flit_i[FlitWidth-1:WrapWidth];
      end
   end

   assign flag      = wrap[0];
   assign credits   = wrap[CreditWidth:1];
   assign push_data = {wrap[CreditWidth+1+UserWidth +: PayloadWidth],
                       wrap[CreditWidth+1 +: UserWidth]};

   assign last = (idx == IdxWidth'(PayloadSplits - 1));

   // Only a data packet whose last flit finds no FIFO room is held back;
   // credit-only packets never need a slot.
   assign stall      = last & ~flag & ~push_ready;
   assign accept     = bus.flit_valid_i & ~stall;
   assign push_valid = accept & last & ~flag;

   assign bus.flit_ready_o = ~stall;

   // ---------------------------------------------------------------------
   // Packet buffer
   // ---------------------------------------------------------------------
   stream_fifo #(
      .DataWidth (PacketWidth),
      .Depth     (NumCredits)
   ) i_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (bus.clear_i),
      .data_i  (push_data),
      .valid_i (push_valid),
      .ready_o (push_ready),
      .data_o  (pop_data),
      .valid_o (pop_valid),
      .ready_i (bus.ready_i)
   );

   assign handshake  = pop_valid & bus.ready_i;
   assign bus.data_o  = pop_data[PacketWidth-1:UserWidth];
   assign bus.user_o  = pop_data[UserWidth-1:0];
   assign bus.valid_o = pop_valid;

   // ---------------------------------------------------------------------
   // Index, credit reporting, free counter, overflow
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx                <= '0;
         credits_rcvd       <= '0;
         credits_rcvd_valid <= 1'b0;
         free_cnt           <= '0;
         overflow           <= 1'b0;
      end else if (bus.clear_i) begin
         idx                <= '0;
         credits_rcvd_valid <= 1'b0;
         free_cnt           <= '0;
         overflow           <= 1'b0;
      end else begin
         credits_rcvd_valid <= 1'b0;
         if (accept) begin
            if (last) begin
               idx                <= '0;
               credits_rcvd       <= credits;
               credits_rcvd_valid <= 1'b1;
            end else begin
               idx <= idx + IdxWidth'(1);
            end
         end

         if (stall && bus.flit_valid_i) begin
            overflow <= 1'b1;
         end

         // A take hands the current count to the TX; a coincident pop
         // starts the next count at one.
         if (bus.credits_free_take_i) begin
            free_cnt <= handshake ? FreeWidth'(1) : '0;
         end else if (handshake && free_cnt != FreeWidth'(NumCredits)) begin
            free_cnt <= free_cnt + FreeWidth'(1);
         end
      end
   end

   assign bus.credits_rcvd_o       = credits_rcvd;
   assign bus.credits_rcvd_valid_o = credits_rcvd_valid;
   assign bus.credits_free_o       = free_cnt;
   assign bus.overflow_o           = overflow;

   // The free count can only exceed NumCredits if more packets were popped
   // than the peer was allowed to send between two credit returns.
   free_no_saturation: assert property (@(posedge clk_i) disable iff (rst_i)
      !(handshake && !bus.credits_free_take_i && !bus.clear_i &&
        free_cnt == FreeWidth'(NumCredits)))
      else $error("credits_free_o saturated");

endmodule
